bus_demux_router: RTL and testbench
===================================

Name: bus_demux_router

Overview:
- Registered 1-to-N data bus demultiplexer: the inverse of the team's N-bus mux.
- One valid/ready input stream carries a data word and a destination select. Each word is routed into a one-entry holding slot for the selected output channel.
- Each output channel drains independently through its own valid/ready handshake.
- Sits between a single producer and N bus consumers; out-of-range selects are discarded and counted.

Parameters:
- NUM_OUT, 8, number of output buses (2..2^SEL_W)
- WIDTH, 8, width of each bus in bits
- SEL_W, 3, width of destination select

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word present
- in_ready  output  1  router can accept the input word this cycle
- in_data  input  WIDTH  input word
- in_sel  input  SEL_W  destination channel index
- out_valid  output  NUM_OUT  per-channel slot occupied
- out_ready  input  NUM_OUT  per-channel consumer accepts
- out_data  output  NUM_OUT*WIDTH  flattened; channel i occupies bits [i*WIDTH +: WIDTH]
- drop_err  output  1  one-cycle pulse: out-of-range word discarded
- drop_count  output  8  saturating count of discarded words

Behaviour:
- Reset: asserting rst_n low immediately forces the following; no handshake completes during reset; any in-flight slot contents are lost.
  - all out_valid = 0, slot data = 0
  - drop_err = 0, drop_count = 0
- Per-channel logic is built with a generate loop over NUM_OUT. Each channel has a slot register holding data plus a valid bit.
- Accept condition: acc = in_valid & in_ready.
- in_ready is combinational, computed from in_sel, the channel state and the channel's out_ready:
  - in_sel >= NUM_OUT: in_ready = 1
  - otherwise: in_ready = ~out_valid[in_sel] | out_ready[in_sel] (pass-through when draining)
- Load: on acc with valid in_sel, slot[in_sel] takes in_data at the next rising edge and out_valid[in_sel] = 1. Latency is 1 cycle from acceptance to out_valid.
- Drain: out_valid[i] & out_ready[i] completes transfer of channel i. out_valid[i] clears next edge unless channel i is loaded in the same cycle.
- Simultaneous drain and load on the same channel: the slot takes the new word and out_valid stays 1. No bubble, no loss.
- Stability: while out_valid[i] = 1 and out_ready[i] = 0, the channel's slot data must not change.
- out_data gating: out_data channel i is forced to all-zero whenever out_valid[i] = 0 (combinational AND with valid).
- Only the addressed channel is affected by an accept. Other channels drain concurrently and independently in the same cycle.
- Out-of-range drop: on acc with in_sel >= NUM_OUT the word is discarded.
  - drop_err = 1 for exactly the next cycle.
  - drop_count increments by 1, saturating at 255.
  - No channel changes state.
- Back-to-back accepts to different channels each cycle are legal. Sustained throughput to one channel is 1 word/cycle while its out_ready is held at 1.
- Input-side rules: in_sel and in_data are sampled only on acc. The producer must hold in_valid, in_data and in_sel stable until accepted.

Test Plan:
- Reset then idle:
  - rst_n low 3 cycles -> out_valid = 8'h00, out_data all zero, in_ready = 1, drop_count = 0.
- Sequential routing:
  - for k = 0..7 send in_data = 8'h10+k, in_sel = k, all out_ready = 0 -> one cycle after each accept out_valid[k] = 1 with channel k data = 8'h10+k.
  - after k = 7, out_valid = 8'hFF.
- Backpressure:
  - channel 3 full, out_ready[3] = 0, in_sel = 3, in_data = 8'hAA -> in_ready = 0 and channel 3 keeps its old value for 5 cycles.
  - raise out_ready[3] -> 8'hAA accepted same cycle; next cycle channel 3 = 8'hAA, out_valid[3] = 1.
- Simultaneous drain and load:
  - channel 2 holds 8'h55, out_ready[2] = 1, in_sel = 2, in_data = 8'h66 in the same cycle -> next cycle out_valid[2] = 1, data 8'h66.
  - consumer has observed exactly one 8'h55 transfer.
- Out-of-range drop (NUM_OUT = 6, SEL_W = 3):
  - in_sel = 6, then in_sel = 7 -> in_ready = 1 each time; drop_err pulses twice; drop_count = 2; out_valid unchanged.
  - 300 drops -> drop_count = 255.
- Reset mid-operation:
  - channels 0, 5 full; assert rst_n asynchronously mid-cycle -> out_valid = 0 immediately without a clock edge.
  - after release, first accept to in_sel = 5 appears after 1 cycle.

Source files
------------

// File: rtl/bus_demux_router.sv
// Registered 1-to-N bus demultiplexer.
// A single valid/ready input stream carries a word and a destination select.
// Each accepted word lands in a one-entry slot for the selected channel, and
// every channel drains through its own valid/ready handshake. Words addressed
// to a channel that does not exist are discarded, flagged and counted.

module bus_demux_router #(
  parameter int NUM_OUT = 8,
  parameter int WIDTH   = 8,
  parameter int SEL_W   = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [SEL_W-1:0]           in_sel,
  output logic [NUM_OUT-1:0]         out_valid,
  input  logic [NUM_OUT-1:0]         out_ready,
  output logic [NUM_OUT*WIDTH-1:0]   out_data,
  output logic                       drop_err,
  output logic [7:0]                 drop_count
);

  logic                 w_acc;
  logic                 w_inReady;
  logic                 w_selInRange;
  logic                 w_drop;
  logic [NUM_OUT-1:0]   w_chanReady;
  logic [NUM_OUT-1:0]   w_valid;
  logic                 r_dropErr;
  logic [7:0]           r_dropCount;

  // Select the addressed channel's readiness; nonexistent channels always accept so the word can be dropped
  always_comb begin
    w_inReady    = 1'b1;
    w_selInRange = 1'b0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (in_sel == SEL_W'(i)) begin
        w_inReady    = w_chanReady[i];
        w_selInRange = 1'b1;
      end
    end
  end

  assign w_acc  = in_valid & w_inReady;
  assign w_drop = w_acc & ~w_selInRange;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_chan
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_load;

    assign w_chanReady[g] = ~r_valid | out_ready[g];
    assign w_load         = w_acc & (in_sel == SEL_W'(g));

    // Slot update: a load wins over a drain so a simultaneous drain+load keeps the channel full
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
      end else if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= in_data;
      end else if (r_valid && out_ready[g]) begin
        r_valid <= 1'b0;
      end
    end

    assign w_valid[g]                  = r_valid;
    assign out_data[g*WIDTH +: WIDTH]  = r_data & {WIDTH{r_valid}};
  end

  // Drop bookkeeping: one-cycle error pulse and a saturating discard counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dropErr   <= 1'b0;
      r_dropCount <= 8'h00;
    end else begin
      r_dropErr <= w_drop;
      if (w_drop && (r_dropCount != 8'hFF)) begin
        r_dropCount <= r_dropCount + 8'h01;
      end
    end
  end

  assign in_ready   = w_inReady;
  assign out_valid  = w_valid;
  assign drop_err   = r_dropErr;
  assign drop_count = r_dropCount;

endmodule

// File: tb/tb_bus_demux_router.sv
// Directed, table-driven bench for bus_demux_router.
// An 8-channel instance covers routing, backpressure, drain/load overlap and
// asynchronous reset; a 6-channel instance covers out-of-range drops.

module tb_bus_demux_router;

  logic        clk;
  logic        rst_n;

  logic        valid8;
  logic        inReady8;
  logic [7:0]  data8;
  logic [2:0]  sel8;
  logic [7:0]  outValid8;
  logic [7:0]  outReady8;
  logic [63:0] outData8;
  logic        dropErr8;
  logic [7:0]  dropCount8;

  logic        valid6;
  logic        inReady6;
  logic [7:0]  data6;
  logic [2:0]  sel6;
  logic [5:0]  outValid6;
  logic [5:0]  outReady6;
  logic [47:0] outData6;
  logic        dropErr6;
  logic [7:0]  dropCount6;

  int checks;
  int failures;
  int seen55;

  bus_demux_router #(.NUM_OUT(8), .WIDTH(8), .SEL_W(3)) dut8 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (valid8),
    .in_ready   (inReady8),
    .in_data    (data8),
    .in_sel     (sel8),
    .out_valid  (outValid8),
    .out_ready  (outReady8),
    .out_data   (outData8),
    .drop_err   (dropErr8),
    .drop_count (dropCount8)
  );

  bus_demux_router #(.NUM_OUT(6), .WIDTH(8), .SEL_W(3)) dut6 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (valid6),
    .in_ready   (inReady6),
    .in_data    (data6),
    .in_sel     (sel6),
    .out_valid  (outValid6),
    .out_ready  (outReady6),
    .out_data   (outData6),
    .drop_err   (dropErr6),
    .drop_count (dropCount6)
  );

  typedef struct {
    logic       inValid;
    logic [2:0] sel;
    logic [7:0] data;
    logic [7:0] ready;
    logic       expInReady;
    logic [7:0] expValid;
    int         chan;
    logic [7:0] expChan;
  } vec_t;

  vec_t vecs[12];

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Consumer-side monitor: counts completed transfers of 8'h55 on channel 2
  always @(posedge clk) begin
    if (rst_n && outValid8[2] && outReady8[2] && (outData8[2*8 +: 8] == 8'h55)) begin
      seen55++;
    end
  end

  function automatic logic [7:0] chan8(input int k);
    return outData8[k*8 +: 8];
  endfunction

  function automatic logic [7:0] chan6(input int k);
    return outData6[k*8 +: 8];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] s, input logic [7:0] d, input logic [7:0] r);
    @(negedge clk);
    valid8    = v;
    sel8      = s;
    data8     = d;
    outReady8 = r;
  endtask

  task automatic applyStimulus6(input logic v, input logic [2:0] s, input logic [7:0] d, input logic [5:0] r);
    @(negedge clk);
    valid6    = v;
    sel6      = s;
    data6     = d;
    outReady6 = r;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    seen55    = 0;
    rst_n     = 1'b0;
    valid8    = 1'b0;
    sel8      = 3'd0;
    data8     = 8'h00;
    outReady8 = 8'h00;
    valid6    = 1'b0;
    sel6      = 3'd0;
    data6     = 8'h00;
    outReady6 = 6'h00;

    // Sequential routing: word 0x10+k to channel k, nobody draining
    for (int k = 0; k < 8; k++) begin
      vecs[k] = '{1'b1, 3'(k), 8'(8'h10 + k), 8'h00, 1'b1,
                  8'((9'h1 << (k + 1)) - 9'h1), k, 8'(8'h10 + k)};
    end
    // Drain channel 0 alone; its data is gated to zero once empty
    vecs[8]  = '{1'b0, 3'd0, 8'h00, 8'h01, 1'b1, 8'hFE, 0, 8'h00};
    // Refill channel 0
    vecs[9]  = '{1'b1, 3'd0, 8'h99, 8'h00, 1'b1, 8'hFF, 0, 8'h99};
    // Full channel 1 without consumer: not accepted, old data kept
    vecs[10] = '{1'b1, 3'd1, 8'hEE, 8'h00, 1'b0, 8'hFF, 1, 8'h11};
    // Pass-through load on channel 4 while channels 1 and 7 drain
    vecs[11] = '{1'b1, 3'd4, 8'h44, 8'h92, 1'b1, 8'h7D, 4, 8'h44};

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(outValid8), 64'h00);
    checkOutput("reset_out_data", outData8, 64'h0);
    checkOutput("reset_in_ready", 64'(inReady8), 64'h1);
    checkOutput("reset_drop_count", 64'(dropCount8), 64'h0);
    checkOutput("reset_drop_err", 64'(dropErr8), 64'h0);
    checkOutput("reset_out_valid6", 64'(outValid6), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors
    for (int v = 0; v < 12; v++) begin
      applyStimulus(vecs[v].inValid, vecs[v].sel, vecs[v].data, vecs[v].ready);
      #1;
      checkOutput($sformatf("vec%0d_in_ready", v), 64'(inReady8), 64'(vecs[v].expInReady));
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_out_valid", v), 64'(outValid8), 64'(vecs[v].expValid));
      checkOutput($sformatf("vec%0d_chan%0d", v, vecs[v].chan), 64'(chan8(vecs[v].chan)), 64'(vecs[v].expChan));
    end

    // Backpressure: channel 3 full, consumer stalled for 5 cycles
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 3'd3, 8'hAA, 8'h00);
      #1;
      checkOutput($sformatf("bp_in_ready_c%0d", c), 64'(inReady8), 64'h0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_hold_c%0d", c), 64'(chan8(3)), 64'h13);
    end
    applyStimulus(1'b1, 3'd3, 8'hAA, 8'h08);
    #1;
    checkOutput("bp_release_in_ready", 64'(inReady8), 64'h1);
    @(posedge clk);
    #1;
    checkOutput("bp_release_data", 64'(chan8(3)), 64'hAA);
    checkOutput("bp_release_valid", 64'(outValid8[3]), 64'h1);

    // Simultaneous drain and load on channel 2
    applyStimulus(1'b1, 3'd2, 8'h55, 8'h04);
    @(posedge clk);
    #1;
    checkOutput("sim_load55", 64'(chan8(2)), 64'h55);
    applyStimulus(1'b1, 3'd2, 8'h66, 8'h04);
    #1;
    checkOutput("sim_in_ready", 64'(inReady8), 64'h1);
    @(posedge clk);
    #1;
    checkOutput("sim_valid", 64'(outValid8[2]), 64'h1);
    checkOutput("sim_data66", 64'(chan8(2)), 64'h66);
    checkOutput("sim_seen55", 64'(seen55), 64'h1);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h04);
    @(posedge clk);
    #1;
    checkOutput("sim_drained_valid", 64'(outValid8[2]), 64'h0);
    checkOutput("sim_drained_data", 64'(chan8(2)), 64'h0);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);

    // Out-of-range drops on the 6-channel instance
    applyStimulus6(1'b1, 3'd0, 8'h77, 6'h00);
    @(posedge clk);
    applyStimulus6(1'b1, 3'd6, 8'hD6, 6'h00);
    #1;
    checkOutput("drop6_in_ready", 64'(inReady6), 64'h1);
    @(posedge clk);
    #1;
    checkOutput("drop6_err", 64'(dropErr6), 64'h1);
    checkOutput("drop6_count", 64'(dropCount6), 64'h1);
    applyStimulus6(1'b1, 3'd7, 8'hD7, 6'h00);
    #1;
    checkOutput("drop7_in_ready", 64'(inReady6), 64'h1);
    @(posedge clk);
    #1;
    checkOutput("drop7_err", 64'(dropErr6), 64'h1);
    checkOutput("drop7_count", 64'(dropCount6), 64'h2);
    applyStimulus6(1'b0, 3'd0, 8'h00, 6'h00);
    @(posedge clk);
    #1;
    checkOutput("drop_err_cleared", 64'(dropErr6), 64'h0);
    checkOutput("drop_count_hold", 64'(dropCount6), 64'h2);
    checkOutput("drop_out_valid", 64'(outValid6), 64'h01);
    checkOutput("drop_chan0", 64'(chan6(0)), 64'h77);
    applyStimulus6(1'b1, 3'd7, 8'h00, 6'h00);
    repeat (300) @(posedge clk);
    #1;
    checkOutput("drop_saturate", 64'(dropCount6), 64'hFF);
    applyStimulus6(1'b0, 3'd0, 8'h00, 6'h00);
    @(posedge clk);
    #1;
    checkOutput("drop_saturate_hold", 64'(dropCount6), 64'hFF);
    checkOutput("drop_saturate_valid", 64'(outValid6), 64'h01);

    // Reset mid-operation: channels 0 and 5 full, then asynchronous reset
    applyStimulus(1'b0, 3'd0, 8'h00, 8'hFF);
    @(posedge clk);
    applyStimulus(1'b1, 3'd0, 8'hA0, 8'h00);
    @(posedge clk);
    applyStimulus(1'b1, 3'd5, 8'hA5, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("pre_reset_valid", 64'(outValid8), 64'h21);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 64'(outValid8), 64'h00);
    checkOutput("async_reset_data", outData8, 64'h0);
    checkOutput("async_reset_count6", 64'(dropCount6), 64'h0);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'd5, 8'h5A, 8'h00);
    @(posedge clk);
    #1;
    checkOutput("post_reset_valid", 64'(outValid8), 64'h20);
    checkOutput("post_reset_chan5", 64'(chan8(5)), 64'h5A);
    applyStimulus(1'b0, 3'd0, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
